unified_mem_arbiter: RTL and testbench
======================================

// Module: unified_mem_arbiter
// PURPOSE
//  Shares the single-port unified instruction/data memory of the multicycle RISC-V core
//  between two requesters: the core (port C) and the program loader/debug DMA (port L).
//  Sits between the core's memory interface (instruction fetch and data access, IorD mux)
//  and the memory macro. Arbitrates, issues exactly one memory access per grant, waits out
//  read latency and returns a one-cycle ack with registered read data.
// PARAMETERS
//  ADDR_W       32  address width, all ports
//  DATA_W       32  data width, all ports
//  RD_LATENCY   1   memory read latency in cycles (m_rdata valid RD_LATENCY cycles after m_en); range 1..4
//  FIXED_PRIO   0   0: round-robin between C and L; 1: L always wins ties (boot load)
// PORTS
//  clk      in   1       clock, rising edge
//  rst      in   1       reset, asynchronous, active-low
//  c_req    in   1       core request; held with c_we/c_addr/c_wdata stable until c_ack
//  c_we     in   1       core write (1) / read (0)
//  c_addr   in   ADDR_W  core address
//  c_wdata  in   DATA_W  core write data
//  c_ack    out  1       one-cycle pulse: core access complete
//  c_rdata  out  DATA_W  core read data, valid with c_ack, held until next core read ack
//  l_req, l_we, l_addr, l_wdata, l_ack, l_rdata: same as c_* for the loader port
//  m_en     out  1       memory access strobe (one cycle per grant)
//  m_we     out  1       memory write enable; only ever high together with m_en
//  m_addr   out  ADDR_W  memory address
//  m_wdata  out  DATA_W  memory write data
//  m_rdata  in   DATA_W  memory read data
//  busy     out  1       high in every state except IDLE
//  owner    out  1       0 = core, 1 = loader; port currently/last granted
// BEHAVIOUR
//  - Reset (rst low, async): state IDLE; all outputs 0 (c_ack, l_ack, c_rdata, l_rdata,
//    m_en, m_we, m_addr, m_wdata, busy, owner); rr pointer favours core. An in-flight access
//    is abandoned with no ack; loss of that access is the requester's concern.
//  - States: IDLE, ISSUE, WAIT, RESP. All outputs registered.
//  - IDLE: if no req stay. Else grant: single req -> that port; both -> FIXED_PRIO=1: L;
//    FIXED_PRIO=0: port not granted last (after reset: C). Latch we/addr/wdata of winner,
//    set owner, -> ISSUE.
//  - ISSUE (1 cycle): m_en=1, m_we=latched we, m_addr/m_wdata=latched. Write -> RESP;
//    read -> WAIT with counter loaded to RD_LATENCY.
//  - WAIT: counter decrements each cycle; m_en=m_we=0; on the cycle counter==1 capture
//    m_rdata into the owner's rdata register, -> RESP. Other port's rdata unchanged.
//  - RESP (1 cycle): owner's ack=1, other ack=0; -> IDLE; rr pointer updated to owner.
//  - Latency req-seen-in-IDLE to ack: write 2 cycles, read 2+RD_LATENCY cycles.
//    Back-to-back: one IDLE cycle between RESP and next ISSUE.
//  - Requester protocol: req and fields held stable until ack; requester drops req on the
//    edge ending the ack cycle, else the still-high req is a new request in IDLE.
//    req changes outside IDLE are ignored (no effect on the access in flight).
//  - A port never receives ack without having requested; at most one ack high per cycle.
//  - Requests arriving during busy wait; never dropped while held.
//  - m_addr/m_wdata hold last value outside ISSUE; m_we low whenever m_en low.
// TESTING
//  1 Reset: drive rst=0 mid-read (state WAIT) -> all outputs 0 same cycle, no ack after release.
//  2 Core read, RD_LATENCY=1: c_req=1,c_we=0,c_addr=0x40, mem returns 0xDEADBEEF ->
//    m_en at cycle+1 with m_addr=0x40, c_ack pulse at cycle+3, c_rdata=0xDEADBEEF, l_ack=0.
//  3 Loader write: l_req=1,l_we=1,l_addr=0x100,l_wdata=0x12345678 -> one m_en&m_we cycle with
//    those values, l_ack at cycle+2, l_rdata unchanged.
//  4 Round-robin: both req held continuously, FIXED_PRIO=0 -> grants C,L,C,L; owner toggles;
//    each ack once per grant; with FIXED_PRIO=1 -> L,L,L until l_req drops, then C.
//  5 RD_LATENCY=3: core read -> ack at cycle+5, data captured from the 3rd cycle after m_en;
//    loader req raised during WAIT is served right after (one IDLE cycle gap).
//  6 Stability: toggle c_addr during WAIT -> m_addr/result unaffected; random C/L traffic
//    vs reference memory model: every read returns last written value, no lost/duplicate acks.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Two-port arbiter for the single-port unified instruction/data memory.
// Port C is the core, port L is the program loader / debug DMA. One memory
// access per grant, fixed read latency, one-cycle ack with registered data.
`timescale 1ns/1ps
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_ack,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_ack,
  output logic [DATA_W-1:0] l_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state, state_next;
  logic       grant_l;
  logic       rr_last;   // port granted last: 0 = core, 1 = loader
  logic       lat_we;
  logic [2:0] cnt;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state and arbitration decision
  always_comb begin
    state_next = state;
    grant_l    = 1'b0;
    case (state)
      IDLE: begin
        if (c_req || l_req) begin
          grant_l    = l_req && (!c_req || (FIXED_PRIO != 0) || !rr_last);
          state_next = ISSUE;
        end
      end
      ISSUE:   state_next = lat_we ? RESP : WAIT;
      WAIT:    if (cnt == 3'd1) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs, computed from the upcoming state so that they are
  // valid during the state they belong to; m_addr/m_wdata double as the
  // latched request fields and hold outside ISSUE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_ack   <= 1'b0;
      l_ack   <= 1'b0;
      c_rdata <= '0;
      l_rdata <= '0;
      m_en    <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      busy    <= 1'b0;
      owner   <= 1'b0;
      rr_last <= 1'b1;
      lat_we  <= 1'b0;
      cnt     <= '0;
    end else begin
      m_en  <= 1'b0;
      m_we  <= 1'b0;
      c_ack <= 1'b0;
      l_ack <= 1'b0;
      busy  <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (state_next == ISSUE) begin
            owner   <= grant_l;
            lat_we  <= grant_l ? l_we : c_we;
            m_en    <= 1'b1;
            m_we    <= grant_l ? l_we : c_we;
            m_addr  <= grant_l ? l_addr : c_addr;
            m_wdata <= grant_l ? l_wdata : c_wdata;
          end
        end
        ISSUE: begin
          if (!lat_we) cnt <= 3'(RD_LATENCY);
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            if (owner) l_rdata <= m_rdata;
            else       c_rdata <= m_rdata;
          end
        end
        RESP:    rr_last <= owner;
        default: ;
      endcase
      if (state_next == RESP) begin
        c_ack <= !owner;
        l_ack <= owner;
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: dut0 (RD_LATENCY=1, round-robin) and
// dut1 (RD_LATENCY=3, loader priority), each with its own memory model.
`timescale 1ns/1ps
module tb_unified_mem_arbiter;
  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        c_req [2], c_we [2], l_req [2], l_we [2];
  logic [31:0] c_addr [2], c_wdata [2], l_addr [2], l_wdata [2];
  logic        c_ack [2], l_ack [2], m_en [2], m_we [2], busy [2], owner [2];
  logic [31:0] c_rdata [2], l_rdata [2], m_addr [2], m_wdata [2], m_rdata [2];

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(1), .FIXED_PRIO(0)) dut0 (
    .clk(clk), .rst(rst),
    .c_req(c_req[0]), .c_we(c_we[0]), .c_addr(c_addr[0]), .c_wdata(c_wdata[0]),
    .c_ack(c_ack[0]), .c_rdata(c_rdata[0]),
    .l_req(l_req[0]), .l_we(l_we[0]), .l_addr(l_addr[0]), .l_wdata(l_wdata[0]),
    .l_ack(l_ack[0]), .l_rdata(l_rdata[0]),
    .m_en(m_en[0]), .m_we(m_we[0]), .m_addr(m_addr[0]), .m_wdata(m_wdata[0]),
    .m_rdata(m_rdata[0]), .busy(busy[0]), .owner(owner[0]));

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(3), .FIXED_PRIO(1)) dut1 (
    .clk(clk), .rst(rst),
    .c_req(c_req[1]), .c_we(c_we[1]), .c_addr(c_addr[1]), .c_wdata(c_wdata[1]),
    .c_ack(c_ack[1]), .c_rdata(c_rdata[1]),
    .l_req(l_req[1]), .l_we(l_we[1]), .l_addr(l_addr[1]), .l_wdata(l_wdata[1]),
    .l_ack(l_ack[1]), .l_rdata(l_rdata[1]),
    .m_en(m_en[1]), .m_we(m_we[1]), .m_addr(m_addr[1]), .m_wdata(m_wdata[1]),
    .m_rdata(m_rdata[1]), .busy(busy[1]), .owner(owner[1]));

  // Memory macros: word array plus a read pipeline; junk outside the valid cycle
  logic [31:0] mem [2][256] = '{default: '0};
  logic [31:0] pd  [2][3]   = '{default: '0};
  logic        pv  [2][3]   = '{default: 1'b0};
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (m_en[d] && m_we[d]) mem[d][m_addr[d][9:2]] <= m_wdata[d];
      pd[d][0] <= mem[d][m_addr[d][9:2]];
      pv[d][0] <= m_en[d] && !m_we[d];
      pd[d][1] <= pd[d][0];
      pv[d][1] <= pv[d][0];
      pd[d][2] <= pd[d][1];
      pv[d][2] <= pv[d][1];
    end
  end
  assign m_rdata[0] = pv[0][0] ? pd[0][0] : JUNK;
  assign m_rdata[1] = pv[1][2] ? pd[1][2] : JUNK;

  // Reference contents and expected held read data
  logic [31:0] ref_mem [2][256] = '{default: '0};
  logic [31:0] exp_rd_c [2] = '{default: '0};
  logic [31:0] exp_rd_l [2] = '{default: '0};

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned viol   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Protocol invariants watched on every cycle outside reset
  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        if (m_we[d] && !m_en[d])  viol++;
        if (c_ack[d] && l_ack[d]) viol++;
        if (c_ack[d] && !c_req[d]) viol++;
        if (l_ack[d] && !l_req[d]) viol++;
      end
    end
  end

  // Single transaction on one port of one DUT, with full checking
  task automatic do_txn(input int d, input bit lp, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int exp_lat, input logic [31:0] exp_rd,
                        input string tag);
    int n, ack_n, men_cnt, spurious;
    logic [31:0] ma, mw, exp_c, exp_l;
    logic mwe, own;
    exp_c = exp_rd_c[d];
    exp_l = exp_rd_l[d];
    if (!we) begin
      if (lp) exp_l = exp_rd;
      else    exp_c = exp_rd;
    end
    n = 0; ack_n = 0; men_cnt = 0; spurious = 0;
    ma = '0; mw = '0; mwe = 1'b0; own = 1'bx;
    @(negedge clk);
    if (lp) begin l_req[d] = 1'b1; l_we[d] = we; l_addr[d] = addr; l_wdata[d] = wdata; end
    else    begin c_req[d] = 1'b1; c_we[d] = we; c_addr[d] = addr; c_wdata[d] = wdata; end
    while (ack_n == 0 && n < 30) begin
      @(negedge clk);
      n++;
      if (m_en[d]) begin men_cnt++; ma = m_addr[d]; mw = m_wdata[d]; mwe = m_we[d]; end
      if (lp ? l_ack[d] : c_ack[d]) begin ack_n = n; own = owner[d]; end
      if (lp ? c_ack[d] : l_ack[d]) spurious++;
    end
    @(posedge clk);
    #1;
    if (lp) l_req[d] = 1'b0;
    else    c_req[d] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (c_ack[d] || l_ack[d]) spurious++;
    end
    check({tag, " latency"}, 32'(ack_n), 32'(exp_lat));
    check({tag, " m_en count"}, 32'(men_cnt), 32'd1);
    check({tag, " m_addr"}, ma, addr);
    check({tag, " m_we"}, 32'(mwe), 32'(we));
    if (we) check({tag, " m_wdata"}, mw, wdata);
    check({tag, " m_addr held"}, m_addr[d], addr);
    check({tag, " owner"}, 32'(own), 32'(lp));
    check({tag, " spurious acks"}, 32'(spurious), 32'd0);
    check({tag, " c_rdata"}, c_rdata[d], exp_c);
    check({tag, " l_rdata"}, l_rdata[d], exp_l);
    if (we) ref_mem[d][addr[9:2]] = wdata;
    exp_rd_c[d] = exp_c;
    exp_rd_l[d] = exp_l;
  endtask

  // Both ports request writes continuously; records grant order
  task automatic run_both(input int d, input int drop_l_after, output logic [3:0] seq,
                          output int first_n, output int last_n);
    int n, k;
    seq = 4'bxxxx; first_n = 0; last_n = 0; n = 0; k = 0;
    @(negedge clk);
    c_req[d] = 1'b1; c_we[d] = 1'b1; c_addr[d] = 32'h200; c_wdata[d] = 32'h0000_00C0;
    l_req[d] = 1'b1; l_we[d] = 1'b1; l_addr[d] = 32'h204; l_wdata[d] = 32'h0000_0010;
    while (k < 4 && n < 60) begin
      @(negedge clk);
      n++;
      if (c_ack[d] || l_ack[d]) begin
        seq[k] = l_ack[d];
        check("rr owner", 32'(owner[d]), 32'(l_ack[d]));
        if (k == 0) first_n = n;
        last_n = n;
        k++;
        if (k == drop_l_after) begin
          @(posedge clk);
          #1 l_req[d] = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    c_req[d] = 1'b0;
    l_req[d] = 1'b0;
    repeat (3) @(negedge clk);
    check("idle busy", 32'(busy[d]), 32'd0);
    ref_mem[d][32'h200 >> 2] = 32'h0000_00C0;
    ref_mem[d][32'h204 >> 2] = 32'h0000_0010;
  endtask

  typedef struct {
    int          d;
    bit          lp;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_lat;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [3:0] seq;
    int first_n, last_n, n, ca, la, bad;

    vecs[0]  = '{0, 1'b1, 1'b1, 32'h040, 32'hDEAD_BEEF, 2, 32'h0};
    vecs[1]  = '{0, 1'b0, 1'b0, 32'h040, 32'h0,         3, 32'hDEAD_BEEF};
    vecs[2]  = '{0, 1'b1, 1'b1, 32'h100, 32'h1234_5678, 2, 32'h0};
    vecs[3]  = '{0, 1'b0, 1'b1, 32'h104, 32'hCAFE_F00D, 2, 32'h0};
    vecs[4]  = '{0, 1'b1, 1'b0, 32'h104, 32'h0,         3, 32'hCAFE_F00D};
    vecs[5]  = '{0, 1'b0, 1'b0, 32'h100, 32'h0,         3, 32'h1234_5678};
    vecs[6]  = '{1, 1'b0, 1'b1, 32'h080, 32'hA5A5_5A5A, 2, 32'h0};
    vecs[7]  = '{1, 1'b0, 1'b0, 32'h080, 32'h0,         5, 32'hA5A5_5A5A};
    vecs[8]  = '{1, 1'b1, 1'b0, 32'h080, 32'h0,         5, 32'hA5A5_5A5A};
    vecs[9]  = '{1, 1'b1, 1'b1, 32'h3FC, 32'hFFFF_FFFF, 2, 32'h0};
    vecs[10] = '{1, 1'b0, 1'b0, 32'h3FC, 32'h0,         5, 32'hFFFF_FFFF};
    vecs[11] = '{0, 1'b0, 1'b0, 32'h000, 32'h0,         3, 32'h0};

    for (int d = 0; d < 2; d++) begin
      c_req[d] = 1'b0; c_we[d] = 1'b0; c_addr[d] = '0; c_wdata[d] = '0;
      l_req[d] = 1'b0; l_we[d] = 1'b0; l_addr[d] = '0; l_wdata[d] = '0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset ctl", 32'({c_ack[d], l_ack[d], m_en[d], m_we[d], busy[d], owner[d]}), 32'd0);
      check("reset data", c_rdata[d] | l_rdata[d] | m_addr[d] | m_wdata[d], 32'd0);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Tie-breaking straight after reset
    run_both(0, 99, seq, first_n, last_n);
    check("rr order", 32'(seq), 32'(4'b1010));
    check("rr first ack", 32'(first_n), 32'd2);
    check("rr last ack", 32'(last_n), 32'd11);
    run_both(1, 3, seq, first_n, last_n);
    check("prio order", 32'(seq), 32'(4'b0111));
    check("prio first ack", 32'(first_n), 32'd2);
    check("prio last ack", 32'(last_n), 32'd11);

    // Directed single-port vectors
    for (int i = 0; i < 12; i++)
      do_txn(vecs[i].d, vecs[i].lp, vecs[i].we, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_lat, vecs[i].exp_rd, $sformatf("vec%0d", i));

    // Core read with RD_LATENCY=3; loader write raised during WAIT
    n = 0; ca = 0; la = 0;
    @(negedge clk);
    c_req[1] = 1'b1; c_we[1] = 1'b0; c_addr[1] = 32'h080;
    while (la == 0 && n < 30) begin
      @(negedge clk);
      n++;
      if (n == 2) begin
        l_req[1] = 1'b1; l_we[1] = 1'b1; l_addr[1] = 32'h084; l_wdata[1] = 32'h1111_2222;
      end
      if (c_ack[1]) begin
        ca = n;
        @(posedge clk);
        #1 c_req[1] = 1'b0;
      end
      if (l_ack[1]) la = n;
    end
    @(posedge clk);
    #1 l_req[1] = 1'b0;
    check("wait c_ack cycle", 32'(ca), 32'd5);
    check("wait c_rdata", c_rdata[1], 32'hA5A5_5A5A);
    check("wait l_ack cycle", 32'(la), 32'd8);
    ref_mem[1][32'h084 >> 2] = 32'h1111_2222;
    exp_rd_c[1] = 32'hA5A5_5A5A;
    repeat (2) @(negedge clk);

    // Request fields changing during WAIT have no effect
    n = 0; ca = 0; bad = 0;
    @(negedge clk);
    c_req[1] = 1'b1; c_we[1] = 1'b0; c_addr[1] = 32'h084;
    while (ca == 0 && n < 30) begin
      @(negedge clk);
      n++;
      if (n >= 2 && n <= 4) begin
        if (m_addr[1] !== 32'h084) bad++;
        c_addr[1] = (n[0]) ? 32'h080 : 32'h3FC;
      end
      if (c_ack[1]) ca = n;
    end
    @(posedge clk);
    #1 c_req[1] = 1'b0;
    check("stable m_addr", 32'(bad), 32'd0);
    check("stable ack cycle", 32'(ca), 32'd5);
    check("stable c_rdata", c_rdata[1], 32'h1111_2222);
    exp_rd_c[1] = 32'h1111_2222;
    repeat (2) @(negedge clk);

    // Reset in the middle of a read
    @(negedge clk);
    c_req[0] = 1'b1; c_we[0] = 1'b0; c_addr[0] = 32'h040;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    c_req[0] = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("async reset ctl", 32'({c_ack[d], l_ack[d], m_en[d], m_we[d], busy[d], owner[d]}), 32'd0);
      check("async reset data", c_rdata[d] | l_rdata[d] | m_addr[d] | m_wdata[d], 32'd0);
      exp_rd_c[d] = '0;
      exp_rd_l[d] = '0;
    end
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (c_ack[0] || l_ack[0] || m_en[0]) bad++;
    end
    check("no ack after reset", 32'(bad), 32'd0);

    // Random serial traffic against the reference contents
    for (int i = 0; i < 40; i++) begin
      int d;
      bit lp, we;
      logic [31:0] a, w;
      d  = i % 2;
      lp = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 15)) << 2;
      w  = $urandom;
      do_txn(d, lp, we, a, w, we ? 2 : 2 + lat(d), ref_mem[d][a[9:2]], $sformatf("rnd%0d", i));
    end

    check("protocol invariants", 32'(viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
